mdr_sequencer: RTL

Control sequencer for the shared multiply / divide / square-root (MDR) datapath. It accepts an operation request, pre-checks the operands for illegal cases, loads the iterative datapath and steps it for the operation-specific number of iterations. It then checks the result for overflow and reports completion or error. It sits between the operand/opcode capture logic and the MDR arithmetic core, and drives the error LED and result-valid indication.

---
 rtl/mdr_sequencer.sv | 93 +++++++++
 1 files changed

// File: rtl/mdr_sequencer.sv
// Control sequencer for the shared multiply/divide/sqrt datapath: pre-checks operands,
// loads and steps the iterative core, then reports done or a sticky error.
module mdr_sequencer #(
    parameter int WORD_LENGTH = 16,
    parameter int CW = $clog2(WORD_LENGTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             opcode,
    input  logic [WORD_LENGTH-1:0] data_y,
    input  logic                   ovf_in,
    output logic                   ready,
    output logic                   busy,
    output logic                   load_en,
    output logic                   step_en,
    output logic [1:0]             op_sel,
    output logic [CW-1:0]          step_cnt,
    output logic                   done,
    output logic                   error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_SQRT = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [CW-1:0] CNT_FULL = CW'(WORD_LENGTH - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(WORD_LENGTH / 2 - 1);

    state_t state;
    state_t nxt;
    logic   accept;
    logic   bad_op;

    assign accept = start && ((state == IDLE) || (state == ERROR));

    assign bad_op = (opcode == OP_RSVD)
                 || ((opcode == OP_DIV)  && (data_y == '0))
                 || ((opcode == OP_SQRT) && data_y[WORD_LENGTH-1]);

    always_comb begin
        nxt = state;
        case (state)
            IDLE, ERROR: if (accept) nxt = bad_op ? ERROR : LOAD;
            LOAD:        nxt = RUN;
            RUN:         if (step_cnt == '0) nxt = CHECK;
            CHECK:       nxt = ((op_sel == OP_MUL) && ovf_in) ? ERROR : DONE;
            DONE:        nxt = IDLE;
            default:     nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they stay Moore yet glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            op_sel   <= OP_MUL;
            step_cnt <= '0;
            ready    <= 1'b1;
            busy     <= 1'b0;
            load_en  <= 1'b0;
            step_en  <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state   <= nxt;
            ready   <= (nxt == IDLE) || (nxt == ERROR);
            busy    <= (nxt == LOAD) || (nxt == RUN) || (nxt == CHECK);
            load_en <= (nxt == LOAD);
            step_en <= (nxt == RUN);
            done    <= (nxt == DONE);
            error   <= (nxt == ERROR);

            if (accept) op_sel <= opcode;

            if (state == LOAD)
                step_cnt <= (op_sel == OP_SQRT) ? CNT_HALF : CNT_FULL;
            else if ((state == RUN) && (step_cnt != '0))
                step_cnt <= step_cnt - 1'b1;
        end
    end

endmodule
